// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and a
// BOOT/RUN/HALT control FSM. Memory reads are combinational on imem_addr,
// so a word fetched in one cycle is presented to decode on the next edge.
module instruction_fetch #(
    parameter int                  BITSIZE  = 32,
    parameter int                  REGSIZE  = 32,
    parameter logic [BITSIZE-1:0]  RESET_PC = 32'h0000_0004
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [BITSIZE-1:0] imem_addr,
    input  logic [BITSIZE-1:0] imem_data,
    input  logic               stall,
    input  logic               redirect,
    input  logic [BITSIZE-1:0] redirect_target,
    input  logic               halt_req,
    output logic [BITSIZE-1:0] pc,
    output logic [BITSIZE-1:0] if_id_instr,
    output logic [BITSIZE-1:0] if_id_pc,
    output logic               if_id_valid,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Last word index that may be fetched; reaching it ends the free run.
    localparam logic [BITSIZE-1:0] LAST_WORD = BITSIZE'(REGSIZE - 1);
    localparam logic [BITSIZE-1:0] PC_STEP   = BITSIZE'(4);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [BITSIZE-1:0] pc_r;
    logic [BITSIZE-1:0] pc_nxt_s;
    logic [BITSIZE-1:0] instr_r;
    logic [BITSIZE-1:0] instr_nxt_s;
    logic [BITSIZE-1:0] if_pc_r;
    logic [BITSIZE-1:0] if_pc_nxt_s;
    logic               valid_r;
    logic               valid_nxt_s;
    logic               halted_r;
    logic               halted_nxt_s;
    logic [BITSIZE-1:0] word_idx_s;
    logic               at_end_s;
    logic [BITSIZE-1:0] target_aligned_s;

    assign word_idx_s       = {2'b00, pc_r[BITSIZE-1:2]};
    assign at_end_s         = (word_idx_s >= LAST_WORD);
    // Low address bits of a redirect are dropped without any error report.
    assign target_aligned_s = {redirect_target[BITSIZE-1:2], 2'b00};

    assign imem_addr   = word_idx_s;
    assign pc          = pc_r;
    assign if_id_instr = instr_r;
    assign if_id_pc    = if_pc_r;
    assign if_id_valid = valid_r;
    assign halted      = halted_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath update decisions; redirect outranks stall.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        instr_nxt_s  = instr_r;
        if_pc_nxt_s  = if_pc_r;
        valid_nxt_s  = valid_r;
        halted_nxt_s = halted_r;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_nxt_s    = target_aligned_s;
                    valid_nxt_s = 1'b0;
                    if (halt_req) begin
                        state_nxt_s  = ST_HALT;
                        halted_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s  = ST_RUN;
                    end
                end else if (stall) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    instr_nxt_s = imem_data;
                    if_pc_nxt_s = pc_r;
                    valid_nxt_s = 1'b1;
                    if (halt_req || at_end_s) begin
                        state_nxt_s  = ST_HALT;
                        halted_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s     = pc_r + PC_STEP;
                    end
                end
            end
            ST_HALT: begin
                valid_nxt_s  = 1'b0;
                halted_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s  = ST_HALT;
                valid_nxt_s  = 1'b0;
                halted_nxt_s = 1'b1;
            end
        endcase
    end

    // PC and IF/ID pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r     <= RESET_PC;
            instr_r  <= {BITSIZE{1'b0}};
            if_pc_r  <= {BITSIZE{1'b0}};
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            pc_r     <= pc_nxt_s;
            instr_r  <= instr_nxt_s;
            if_pc_r  <= if_pc_nxt_s;
            valid_r  <= valid_nxt_s;
            halted_r <= halted_nxt_s;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 32-word instruction memory model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] mem [0:31];
    int          chk_cnt;
    int          pass_cnt;

    instruction_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .pc              (pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd32) ? mem[imem_addr[4:0]] : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        halt_req        = 1'b0;
    endtask

    // Hold reset over a couple of edges, release at a falling edge.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #22;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Boot cycle then two fetches, starting right after reset release.
    task automatic check_boot_seq(input string tag);
        tick();
        chk_cnt++; if (pc !== 32'd4) $display("FAIL %s_boot_pc got %h exp %h", tag, pc, 32'd4); else pass_cnt++;
        chk_cnt++; if (if_id_valid !== 1'b0) $display("FAIL %s_boot_valid got %b exp 0", tag, if_id_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (if_id_pc !== 32'd4) $display("FAIL %s_c2_ifpc got %h exp %h", tag, if_id_pc, 32'd4); else pass_cnt++;
        chk_cnt++; if (if_id_valid !== 1'b1) $display("FAIL %s_c2_valid got %b exp 1", tag, if_id_valid); else pass_cnt++;
        chk_cnt++; if (pc !== 32'd8) $display("FAIL %s_c2_pc got %h exp %h", tag, pc, 32'd8); else pass_cnt++;
        chk_cnt++; if (if_id_instr !== 32'hC000_0001) $display("FAIL %s_c2_instr got %h exp %h", tag, if_id_instr, 32'hC000_0001); else pass_cnt++;
        tick();
        chk_cnt++; if (if_id_pc !== 32'd8) $display("FAIL %s_c3_ifpc got %h exp %h", tag, if_id_pc, 32'd8); else pass_cnt++;
        chk_cnt++; if (pc !== 32'd12) $display("FAIL %s_c3_pc got %h exp %h", tag, pc, 32'd12); else pass_cnt++;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk_cnt++; if (pc !== 32'd4) $display("FAIL rst_pc got %h exp %h", pc, 32'd4); else pass_cnt++;
        chk_cnt++; if (imem_addr !== 32'd1) $display("FAIL rst_imem_addr got %h exp %h", imem_addr, 32'd1); else pass_cnt++;
        chk_cnt++; if (if_id_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if_id_valid); else pass_cnt++;
        chk_cnt++; if (if_id_pc !== 32'd0) $display("FAIL rst_ifpc got %h exp 0", if_id_pc); else pass_cnt++;
        chk_cnt++; if (if_id_instr !== 32'd0) $display("FAIL rst_instr got %h exp 0", if_id_instr); else pass_cnt++;
        chk_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted got %b exp 0", halted); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        check_boot_seq("run");
    endtask

    // pc=12 here; stall with a concurrent halt_req which must be ignored.
    task automatic test_stall();
        stall    = 1'b1;
        halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++; if (pc !== 32'd12) $display("FAIL stall_pc%0d got %h exp %h", i, pc, 32'd12); else pass_cnt++;
            chk_cnt++; if (if_id_pc !== 32'd8 || if_id_valid !== 1'b1 || if_id_instr !== 32'hC000_0002)
                $display("FAIL stall_ifid%0d got %h/%b/%h exp %h/1/%h", i, if_id_pc, if_id_valid, if_id_instr, 32'd8, 32'hC000_0002);
            else pass_cnt++;
            chk_cnt++; if (halted !== 1'b0) $display("FAIL stall_halt%0d got %b exp 0", i, halted); else pass_cnt++;
        end
        clear_inputs();
        tick();
        chk_cnt++; if (if_id_pc !== 32'd12) $display("FAIL unstall_ifpc got %h exp %h", if_id_pc, 32'd12); else pass_cnt++;
        chk_cnt++; if (pc !== 32'd16) $display("FAIL unstall_pc got %h exp %h", pc, 32'd16); else pass_cnt++;
    endtask

    // pc=16: misaligned redirect with stall; redirect wins and flushes.
    task automatic test_redirect();
        redirect        = 1'b1;
        redirect_target = 32'h23;
        stall           = 1'b1;
        tick();
        chk_cnt++; if (pc !== 32'h20) $display("FAIL redir_pc got %h exp %h", pc, 32'h20); else pass_cnt++;
        chk_cnt++; if (if_id_valid !== 1'b0) $display("FAIL redir_valid got %b exp 0", if_id_valid); else pass_cnt++;
        chk_cnt++; if (if_id_pc !== 32'd12) $display("FAIL redir_ifpc_hold got %h exp %h", if_id_pc, 32'd12); else pass_cnt++;
        clear_inputs();
        tick();
        chk_cnt++; if (if_id_pc !== 32'h20 || if_id_valid !== 1'b1) $display("FAIL redir_fetch got %h/%b exp %h/1", if_id_pc, if_id_valid, 32'h20); else pass_cnt++;
        chk_cnt++; if (if_id_instr !== 32'hC000_0008) $display("FAIL redir_instr got %h exp %h", if_id_instr, 32'hC000_0008); else pass_cnt++;
    endtask

    // Redirect to pc=20, then halt_req; redirect afterwards is ignored.
    task automatic test_halt();
        redirect        = 1'b1;
        redirect_target = 32'd20;
        tick();
        clear_inputs();
        halt_req = 1'b1;
        tick();
        chk_cnt++; if (if_id_pc !== 32'd20 || if_id_valid !== 1'b1) $display("FAIL halt_cap got %h/%b exp %h/1", if_id_pc, if_id_valid, 32'd20); else pass_cnt++;
        chk_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag got %b exp 1", halted); else pass_cnt++;
        chk_cnt++; if (pc !== 32'd20) $display("FAIL halt_pc got %h exp %h", pc, 32'd20); else pass_cnt++;
        clear_inputs();
        redirect        = 1'b1;
        redirect_target = 32'h40;
        tick();
        chk_cnt++; if (if_id_valid !== 1'b0) $display("FAIL halt_valid got %b exp 0", if_id_valid); else pass_cnt++;
        chk_cnt++; if (pc !== 32'd20) $display("FAIL halt_redir_pc got %h exp %h", pc, 32'd20); else pass_cnt++;
        tick();
        chk_cnt++; if (halted !== 1'b1 || pc !== 32'd20) $display("FAIL halt_stay got %b/%h exp 1/%h", halted, pc, 32'd20); else pass_cnt++;
        clear_inputs();
    endtask

    // halt_req together with redirect: redirect applied, HALT with valid=0.
    task automatic test_halt_redirect();
        do_reset();
        tick();
        tick();
        redirect        = 1'b1;
        redirect_target = 32'h31;
        halt_req        = 1'b1;
        tick();
        chk_cnt++; if (pc !== 32'h30) $display("FAIL hr_pc got %h exp %h", pc, 32'h30); else pass_cnt++;
        chk_cnt++; if (halted !== 1'b1 || if_id_valid !== 1'b0) $display("FAIL hr_state got %b/%b exp 1/0", halted, if_id_valid); else pass_cnt++;
        clear_inputs();
    endtask

    // Free run from reset until the last memory word triggers HALT.
    task automatic test_free_run();
        logic [31:0] max_addr;
        do_reset();
        max_addr = imem_addr;
        for (int i = 0; i < 100 && !halted; i++) begin
            tick();
            if (imem_addr > max_addr) max_addr = imem_addr;
        end
        chk_cnt++; if (halted !== 1'b1) $display("FAIL free_timeout got %b exp 1", halted); else pass_cnt++;
        chk_cnt++; if (pc !== 32'd124) $display("FAIL free_pc got %0d exp 124", pc); else pass_cnt++;
        chk_cnt++; if (if_id_pc !== 32'd124 || if_id_instr !== 32'hC000_001F) $display("FAIL free_last got %h/%h exp %h/%h", if_id_pc, if_id_instr, 32'd124, 32'hC000_001F); else pass_cnt++;
        chk_cnt++; if (max_addr !== 32'd31) $display("FAIL free_maxaddr got %0d exp 31", max_addr); else pass_cnt++;
        tick();
        chk_cnt++; if (imem_addr !== 32'd31 || if_id_valid !== 1'b0) $display("FAIL free_hold got %0d/%b exp 31/0", imem_addr, if_id_valid); else pass_cnt++;
    endtask

    // Run to pc=40, assert rst_n mid-cycle with stall/redirect active.
    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk_cnt++; if (pc !== 32'd40) $display("FAIL ar_pre_pc got %0d exp 40", pc); else pass_cnt++;
        stall           = 1'b1;
        redirect        = 1'b1;
        redirect_target = 32'h50;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (pc !== 32'd4 || if_id_valid !== 1'b0 || halted !== 1'b0) $display("FAIL ar_ctrl got %h/%b/%b exp 4/0/0", pc, if_id_valid, halted); else pass_cnt++;
        chk_cnt++; if (if_id_pc !== 32'd0 || if_id_instr !== 32'd0) $display("FAIL ar_ifid got %h/%h exp 0/0", if_id_pc, if_id_instr); else pass_cnt++;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_boot_seq("rerun");
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hC000_0000 | i;
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_halt_redirect();
        test_free_run();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter BITSIZE, default 32: instruction and PC width, bits.
REQ-002 Parameter REGSIZE, default 32: instruction memory depth, words.
REQ-003 Parameter RESET_PC, default 32'h0000_0004: byte address of the first fetch after reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 imem_addr  output  BITSIZE  word index to instruction memory, equal to pc[BITSIZE-1:2] zero-extended.
REQ-007 imem_data  input  BITSIZE  instruction word returned combinationally for imem_addr.
REQ-008 stall  input  1  hold the PC and the IF/ID register this cycle.
REQ-009 redirect  input  1  taken branch or jump from downstream; load redirect_target.
REQ-010 redirect_target  input  BITSIZE  byte address of the next fetch when redirect=1.
REQ-011 halt_req  input  1  stop fetching after the current word.
REQ-012 pc  output  BITSIZE  current fetch byte address.
REQ-013 if_id_instr  output  BITSIZE  registered instruction for decode.
REQ-014 if_id_pc  output  BITSIZE  byte address of if_id_instr.
REQ-015 if_id_valid  output  1  if_id_instr/if_id_pc hold a real instruction.
REQ-016 halted  output  1  block is in the HALT state.

Function
REQ-017 The block SHALL implement a three-state FSM: BOOT, RUN, HALT.
REQ-018 BOOT SHALL last exactly one cycle after rst_n deasserts, perform no capture, hold pc, and go to RUN unconditionally.
REQ-019 In RUN, with stall=0 and redirect=0, each edge SHALL load if_id_instr<=imem_data, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4, giving one-cycle fetch-to-decode latency.
REQ-020 In RUN, with stall=1 and redirect=0, pc, if_id_instr, if_id_pc and if_id_valid SHALL hold their values.
REQ-021 In RUN, redirect=1 SHALL take priority over stall: pc<={redirect_target[BITSIZE-1:2],2'b00} and if_id_valid<=0 (flush), with if_id_instr/if_id_pc unchanged.
REQ-022 Misaligned redirect_target bits [1:0] SHALL be silently cleared; no error is flagged.
REQ-023 In RUN, halt_req=1 with stall=0 and redirect=0 SHALL capture the current word as in REQ-019, leave pc unchanged, and enter HALT.
REQ-024 In RUN, when pc[BITSIZE-1:2] >= REGSIZE-1 and no stall or redirect is active, the word SHALL be captured, pc SHALL hold, and the FSM SHALL enter HALT; pc SHALL never index beyond memory depth and SHALL never wrap.
REQ-025 halt_req together with stall SHALL be ignored; halt_req together with redirect SHALL apply the redirect and enter HALT with if_id_valid=0.
REQ-026 In HALT: pc holds, if_id_valid<=0 on the first HALT edge and stays 0, halted=1, and stall/redirect/halt_req are ignored; only reset exits HALT.
REQ-027 imem_addr SHALL be purely combinational from pc and always valid, including during BOOT and HALT.

Reset
REQ-028 While rst_n=0: pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0, FSM=BOOT, applied asynchronously, including mid-stall or mid-redirect.
REQ-029 The reset release SHALL be treated synchronously: the first active edge after deassertion is the BOOT cycle.

Verification
REQ-030 Reset release, stall=0: cycle1 BOOT with pc=4 and valid=0; cycle2 if_id_pc=4 and valid=1, pc=8; cycle3 if_id_pc=8, pc=12.
REQ-031 With pc=12, stall=1 for 3 cycles: pc stays 12 and the IF/ID outputs are frozen; after stall drops, the next edge gives if_id_pc=12, pc=16.
REQ-032 With pc=16, redirect=1, target=32'h23, stall=1: next edge pc=32'h20, valid=0; the following edge gives if_id_pc=32'h20, valid=1.
REQ-033 With pc=20, halt_req=1: next edge if_id_pc=20, valid=1, halted=1, pc=20; the following edge valid=0; redirect is then ignored.
REQ-034 Free run from RESET_PC: halt occurs with pc=124 (word 31) captured; imem_addr never exceeds 31.
REQ-035 rst_n pulsed low mid-run at pc=40: all outputs reach reset values immediately without a clock edge; after release, the BOOT-then-RUN sequence of REQ-030 repeats.
